// File: rtl/pf_pkg.sv
// Shared types and helpers for the stream prefetch buffer.
package pf_pkg;

   localparam int PF_MODE_NEXTLINE = 0;
   localparam int PF_MODE_STRIDE   = 1;

   typedef enum logic {IDLE, ISSUE} pf_state_t;

   function automatic logic [31:0] blk_of(input logic [31:0] addr, input int offset_bits);
      return addr >> offset_bits;
   endfunction

endpackage

// File: rtl/pf_tag_array.sv
// Fully-associative valid+tag store with parallel lookup, invalidate,
// duplicate-checked insert and a round-robin replacement pointer.
module pf_tag_array
   import pf_pkg::*;
#(
   parameter int ENTRIES = 8,
   parameter int TAG_W   = 28,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             lk_hit,
   output logic [IDX_W-1:0] lk_idx,
   input  logic             inv_en,
   input  logic [IDX_W-1:0] inv_idx,
   input  logic             ins_en,
   input  logic [TAG_W-1:0] ins_tag
);

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag [ENTRIES];
   logic [IDX_W-1:0]   wr_ptr;
   logic               dup;
   logic               ins_do;

   always_comb begin
      lk_hit = 1'b0;
      lk_idx = '0;
      dup    = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && (tag[i] == lk_tag)) begin
            lk_hit = 1'b1;
            lk_idx = IDX_W'(i);
         end
         if (valid[i] && (tag[i] == ins_tag)) begin
            dup = 1'b1;
         end
      end
   end

   assign ins_do = ins_en && !dup;

   // Allocation takes priority when it targets the entry being invalidated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= '0;
         wr_ptr <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (ins_do && (wr_ptr == IDX_W'(i))) begin
               valid[i] <= 1'b1;
            end else if (inv_en && (inv_idx == IDX_W'(i))) begin
               valid[i] <= 1'b0;
            end
         end
         if (ins_do) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ins_do) begin
         tag[wr_ptr] <= ins_tag;
      end
   end

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Miss-triggered prefetcher: buffer lookup, next-line/stride stream
// generation over a valid/ready port, and saturating statistics.
module stream_prefetch_buffer
   import pf_pkg::*;
#(
   parameter int BLOCK_SIZE_BYTE = 16,
   parameter int PF_ENTRIES      = 8,
   parameter int PF_DEGREE       = 2,
   parameter int PF_MODE         = 0,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      address,
   input  logic             cache_miss,
   output logic             prefetch_hit,
   output logic             pf_req_valid,
   input  logic             pf_req_ready,
   output logic [31:0]      pf_req_addr,
   output logic             pf_busy,
   output logic [CNT_W-1:0] pf_issued_cnt,
   output logic [CNT_W-1:0] pf_hit_cnt
);

   localparam int OFFSET_BITS = $clog2(BLOCK_SIZE_BYTE);
   localparam int BLK_W       = 32 - OFFSET_BITS;
   localparam int IDX_W       = $clog2(PF_ENTRIES);

   pf_state_t        state, state_n;
   logic [BLK_W-1:0] blk;
   logic [BLK_W-1:0] diff;
   logic [BLK_W-1:0] last_blk;
   logic [BLK_W-1:0] last_stride;
   logic [BLK_W-1:0] stride;
   logic [BLK_W-1:0] base, base_n;
   logic [BLK_W-1:0] step, step_n;
   logic [3:0]       remain, remain_n;
   logic             trigger;
   logic             hs;
   logic             lk_hit;
   logic [IDX_W-1:0] lk_idx;
   logic             miss_hit;

   assign blk  = BLK_W'(blk_of(address, OFFSET_BITS));
   assign diff = blk - last_blk;

   always_comb begin
      trigger = 1'b0;
      stride  = BLK_W'(1);
      if (cache_miss) begin
         if (PF_MODE == PF_MODE_NEXTLINE) begin
            trigger = 1'b1;
         end else begin
            trigger = (diff == last_stride) && (diff != '0);
            stride  = diff;
         end
      end
   end

   assign hs       = (state == ISSUE) && pf_req_ready;
   assign miss_hit = cache_miss && lk_hit;

   pf_tag_array #(
      .ENTRIES (PF_ENTRIES),
      .TAG_W   (BLK_W)
   ) u_tags (
      .clk     (clk),
      .rst_n   (rst_n),
      .lk_tag  (blk),
      .lk_hit  (lk_hit),
      .lk_idx  (lk_idx),
      .inv_en  (miss_hit),
      .inv_idx (lk_idx),
      .ins_en  (hs),
      .ins_tag (base)
   );

   // A new trigger overrides the stream; a coincident handshake still retires first.
   always_comb begin
      state_n  = state;
      base_n   = base;
      step_n   = step;
      remain_n = remain;
      if (hs) begin
         base_n   = base + step;
         remain_n = remain - 4'd1;
         if (remain == 4'd1) begin
            state_n = IDLE;
         end
      end
      if (trigger) begin
         base_n   = blk + stride;
         step_n   = stride;
         remain_n = 4'(PF_DEGREE);
         state_n  = ISSUE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         base        <= '0;
         step        <= '0;
         remain      <= '0;
         last_blk    <= '0;
         last_stride <= '0;
      end else begin
         state  <= state_n;
         base   <= base_n;
         step   <= step_n;
         remain <= remain_n;
         if (cache_miss) begin
            last_blk    <= blk;
            last_stride <= diff;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prefetch_hit  <= 1'b0;
         pf_issued_cnt <= '0;
         pf_hit_cnt    <= '0;
      end else begin
         prefetch_hit <= miss_hit;
         if (hs && (pf_issued_cnt != '1)) begin
            pf_issued_cnt <= pf_issued_cnt + CNT_W'(1);
         end
         if (miss_hit && (pf_hit_cnt != '1)) begin
            pf_hit_cnt <= pf_hit_cnt + CNT_W'(1);
         end
      end
   end

   assign pf_req_valid = (state == ISSUE);
   assign pf_busy      = (state != IDLE);
   assign pf_req_addr  = pf_req_valid ? {base, {OFFSET_BITS{1'b0}}} : 32'h0;

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Directed bench for stream_prefetch_buffer: one next-line and one stride instance.
module tb_stream_prefetch_buffer;

   logic        clk;
   logic        rst_n;
   logic [31:0] address;
   logic        cache_miss;
   logic        ready;

   logic        hit0, valid0, busy0;
   logic [31:0] addr0, issued0, hcnt0;
   logic        hit1, valid1, busy1;
   logic [31:0] addr1, issued1, hcnt1;

   int total = 0;
   int bad   = 0;

   stream_prefetch_buffer #(.PF_MODE(0)) dut0 (
      .clk           (clk),
      .rst_n         (rst_n),
      .address       (address),
      .cache_miss    (cache_miss),
      .prefetch_hit  (hit0),
      .pf_req_valid  (valid0),
      .pf_req_ready  (ready),
      .pf_req_addr   (addr0),
      .pf_busy       (busy0),
      .pf_issued_cnt (issued0),
      .pf_hit_cnt    (hcnt0)
   );

   stream_prefetch_buffer #(.PF_MODE(1)) dut1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .address       (address),
      .cache_miss    (cache_miss),
      .prefetch_hit  (hit1),
      .pf_req_valid  (valid1),
      .pf_req_ready  (ready),
      .pf_req_addr   (addr1),
      .pf_busy       (busy1),
      .pf_issued_cnt (issued1),
      .pf_hit_cnt    (hcnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic miss(input logic [31:0] a);
      address    = a;
      cache_miss = 1'b1;
      step();
      cache_miss = 1'b0;
   endtask

   task automatic do_reset();
      cache_miss = 1'b0;
      rst_n      = 1'b0;
      #2;
      rst_n      = 1'b1;
      step();
   endtask

   initial begin
      rst_n      = 1'b0;
      address    = '0;
      cache_miss = 1'b0;
      ready      = 1'b1;
      step();
      rst_n = 1'b1;
      check("rst_valid", {31'b0, valid0}, 32'd0);
      check("rst_issued", issued0, 32'd0);
      check("rst_hitcnt", hcnt0, 32'd0);
      check("rst_hit", {31'b0, hit0}, 32'd0);

      // next-line
      do_reset();
      miss(32'h100);
      check("nl_hit0", {31'b0, hit0}, 32'd0);
      check("nl_valid_a", {31'b0, valid0}, 32'd1);
      check("nl_busy", {31'b0, busy0}, 32'd1);
      check("nl_addr_a", addr0, 32'h110);
      step();
      check("nl_addr_b", addr0, 32'h120);
      check("nl_issued1", issued0, 32'd1);
      step();
      check("nl_idle", {31'b0, valid0}, 32'd0);
      check("nl_busy_off", {31'b0, busy0}, 32'd0);
      check("nl_issued2", issued0, 32'd2);
      miss(32'h110);
      check("nl_pfhit", {31'b0, hit0}, 32'd1);
      check("nl_hitcnt", hcnt0, 32'd1);
      step();
      check("nl_pfhit_pulse", {31'b0, hit0}, 32'd0);
      step();
      step();
      miss(32'h110);
      check("nl_rehit", {31'b0, hit0}, 32'd0);
      check("nl_hitcnt_hold", hcnt0, 32'd1);
      step();
      step();

      // asynchronous reset mid-stream
      miss(32'h500);
      check("ar_addr", addr0, 32'h510);
      step();
      check("ar_valid_pre", {31'b0, valid0}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("ar_valid_drop", {31'b0, valid0}, 32'd0);
      check("ar_busy_drop", {31'b0, busy0}, 32'd0);
      check("ar_issued", issued0, 32'd0);
      check("ar_hitcnt", hcnt0, 32'd0);
      #1;
      rst_n = 1'b1;
      step();
      miss(32'h510);
      check("ar_nohit", {31'b0, hit0}, 32'd0);
      step();
      step();

      // backpressure
      do_reset();
      ready = 1'b0;
      miss(32'h200);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'b0, valid0}, 32'd1);
         check("bp_addr", addr0, 32'h210);
         step();
      end
      check("bp_issued0", issued0, 32'd0);
      ready = 1'b1;
      check("bp_addr_a", addr0, 32'h210);
      step();
      check("bp_addr_b", addr0, 32'h220);
      check("bp_issued1", issued0, 32'd1);
      step();
      check("bp_done", {31'b0, valid0}, 32'd0);
      check("bp_issued2", issued0, 32'd2);

      // stride detection
      do_reset();
      miss(32'h1000);
      check("st_none1", {31'b0, valid1}, 32'd0);
      miss(32'h1040);
      check("st_none2", {31'b0, valid1}, 32'd0);
      miss(32'h1080);
      check("st_valid", {31'b0, valid1}, 32'd1);
      check("st_addr_a", addr1, 32'h10C0);
      step();
      check("st_addr_b", addr1, 32'h1100);
      step();
      check("st_done", {31'b0, valid1}, 32'd0);
      check("st_issued", issued1, 32'd2);

      // wrap and duplicate suppression
      do_reset();
      miss(32'hFFFF_FFF0);
      check("wr_addr_a", addr0, 32'h0000_0000);
      check("wr_valid", {31'b0, valid0}, 32'd1);
      step();
      check("wr_addr_b", addr0, 32'h0000_0010);
      step();
      check("wr_ptr1", {29'b0, dut0.u_tags.wr_ptr}, 32'd2);
      miss(32'hFFFF_FFF0);
      check("wr_nohit", {31'b0, hit0}, 32'd0);
      step();
      step();
      check("wr_issued", issued0, 32'd4);
      check("wr_ptr2", {29'b0, dut0.u_tags.wr_ptr}, 32'd2);

      // abort and restart
      do_reset();
      miss(32'h300);
      check("ab_addr_a", addr0, 32'h310);
      miss(32'h800);
      check("ab_addr_b", addr0, 32'h810);
      check("ab_issued1", issued0, 32'd1);
      step();
      check("ab_addr_c", addr0, 32'h820);
      step();
      check("ab_done", {31'b0, valid0}, 32'd0);
      check("ab_issued3", issued0, 32'd3);
      miss(32'h310);
      check("ab_resident", {31'b0, hit0}, 32'd1);
      check("ab_hitcnt", hcnt0, 32'd1);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
